// File: rtl/matrix_pkg.sv
// Shared definitions for the random-matrix generator sequencer:
// store geometry, watchdog length, FSM state encoding and error codes.
package matrix_pkg;

  localparam int MAX_DIM    = 5;
  localparam int SLOTS      = 8;
  localparam int SLOT_WORDS = 32;
  localparam int TIMEOUT    = 64;

  localparam int SLOT_W = $clog2(SLOTS);
  localparam int IDX_W  = $clog2(SLOT_WORDS);
  localparam int ADDR_W = SLOT_W + IDX_W;
  localparam int WD_W   = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_ERROR  = 3'd2,
    ST_START  = 3'd3,
    ST_RUN    = 3'd4,
    ST_FINISH = 3'd5,
    ST_DRAIN  = 3'd6
  } state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_DIM      = 3'd1;
  localparam logic [2:0] ERR_COUNT    = 3'd2;
  localparam logic [2:0] ERR_RANGE    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
  localparam logic [2:0] ERR_MISMATCH = 3'd5;

endpackage

// File: rtl/slot_addr_gen.sv
// Turns accepted generator strobes into registered store writes.
// Tracks the element index inside the current slot and advances the
// slot (modulo SLOTS) each time a full matrix has been written.
module slot_addr_gen
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [SLOT_W-1:0] load_slot,
  input  logic [IDX_W-1:0]  elem_last,
  input  logic              strobe,
  input  logic [7:0]        data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata
);

  logic [SLOT_W-1:0] cur_slot;
  logic [IDX_W-1:0]  elem_idx;

  // Slot/index counters and the write registered one cycle after each strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_slot  <= '0;
      elem_idx  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (load) begin
        cur_slot <= load_slot;
        elem_idx <= '0;
      end else if (strobe) begin
        mem_we    <= 1'b1;
        mem_addr  <= {cur_slot, elem_idx};
        mem_wdata <= data;
        if (elem_idx == elem_last) begin
          elem_idx <= '0;
          cur_slot <= cur_slot + 1'b1;
        end else begin
          elem_idx <= elem_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rand_gen_ctrl.sv
// Random-matrix generator sequencer: validates a request, starts the
// generator, maps its strobes onto store slots, supervises it with a
// watchdog and checks the element count on completion.
//
//   state  | meaning
//   IDLE   | ready for a request
//   CHECK  | validate latched dims, count, element range
//   ERROR  | pulse err for a rejected request
//   START  | pulse gen_start, load slot counters
//   RUN    | forward strobes to the store, watchdog active
//   FINISH | compare element total, pulse done or err
//   DRAIN  | discard strobes until gen_done or watchdog expiry
module rand_gen_ctrl
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_dim_m,
  input  logic [2:0]        req_dim_n,
  input  logic [3:0]        req_count,
  input  logic [7:0]        cfg_elem_min,
  input  logic [7:0]        cfg_elem_max,
  input  logic              abort,
  output logic              gen_start,
  output logic [2:0]        gen_dim_m,
  output logic [2:0]        gen_dim_n,
  output logic [3:0]        gen_count,
  input  logic              gen_write_en,
  input  logic [7:0]        gen_data,
  input  logic              gen_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [SLOT_W-1:0] res_base,
  output logic [3:0]        res_count
);

  state_t            state;
  logic [7:0]        lat_min;
  logic [7:0]        lat_max;
  logic [SLOT_W-1:0] slot_ptr;
  logic [8:0]        total;
  logic [WD_W-1:0]   wd_cnt;

  logic [5:0]        elems_per_mat;
  logic [8:0]        job_total;
  logic [IDX_W-1:0]  elem_last;
  logic              strobe_ok;

  // Only checked jobs reach RUN, so m*n <= 25 and the 9-bit job total cannot overflow
  assign elems_per_mat = {3'b000, gen_dim_m} * {3'b000, gen_dim_n};
  assign job_total     = {3'b000, elems_per_mat} * {5'b00000, gen_count};
  assign elem_last     = IDX_W'(elems_per_mat - 6'd1);
  // A strobe arriving with abort is dropped so nothing is written once the job is cancelled
  assign strobe_ok     = (state == ST_RUN) && gen_write_en && !abort;

  slot_addr_gen u_slot_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (state == ST_START),
    .load_slot (slot_ptr),
    .elem_last (elem_last),
    .strobe    (strobe_ok),
    .data      (gen_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  // Sequencer FSM with registered handshake, status and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      gen_start <= 1'b0;
      gen_dim_m <= '0;
      gen_dim_n <= '0;
      gen_count <= '0;
      lat_min   <= '0;
      lat_max   <= '0;
      slot_ptr  <= '0;
      total     <= '0;
      wd_cnt    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      res_base  <= '0;
      res_count <= '0;
    end else begin
      gen_start <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            gen_dim_m <= req_dim_m;
            gen_dim_n <= req_dim_n;
            gen_count <= req_count;
            lat_min   <= cfg_elem_min;
            lat_max   <= cfg_elem_max;
            err_code  <= ERR_NONE;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (gen_dim_m == 3'd0 || gen_dim_m > 3'(MAX_DIM) ||
              gen_dim_n == 3'd0 || gen_dim_n > 3'(MAX_DIM)) begin
            err_code <= ERR_DIM;
            state    <= ST_ERROR;
          end else if (gen_count == 4'd0 || gen_count > 4'(SLOTS)) begin
            err_code <= ERR_COUNT;
            state    <= ST_ERROR;
          end else if ($signed(lat_min) > $signed(lat_max)) begin
            err_code <= ERR_RANGE;
            state    <= ST_ERROR;
          end else begin
            state <= ST_START;
          end
        end
        ST_ERROR: begin
          err       <= 1'b1;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        ST_START: begin
          gen_start <= 1'b1;
          total     <= '0;
          wd_cnt    <= WD_W'(TIMEOUT - 1);
          state     <= ST_RUN;
        end
        ST_RUN: begin
          if (abort) begin
            wd_cnt <= WD_W'(TIMEOUT - 1);
            state  <= ST_DRAIN;
          end else begin
            if (gen_write_en) begin
              total <= total + 9'd1;
            end
            if (gen_done) begin
              state <= ST_FINISH;
            end else if (gen_write_en) begin
              wd_cnt <= WD_W'(TIMEOUT - 1);
            end else if (wd_cnt == '0) begin
              err_code <= ERR_TIMEOUT;
              wd_cnt   <= WD_W'(TIMEOUT - 1);
              state    <= ST_DRAIN;
            end else begin
              wd_cnt <= wd_cnt - 1'b1;
            end
          end
        end
        ST_FINISH: begin
          if (total == job_total) begin
            done      <= 1'b1;
            res_base  <= slot_ptr;
            res_count <= gen_count;
            // count == SLOTS wraps back to the same pointer
            slot_ptr  <= slot_ptr + gen_count[SLOT_W-1:0];
          end else begin
            err_code <= ERR_MISMATCH;
            err      <= 1'b1;
          end
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (gen_done || (!gen_write_en && wd_cnt == '0)) begin
            err       <= (err_code != ERR_NONE);
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else if (gen_write_en) begin
            wd_cnt <= WD_W'(TIMEOUT - 1);
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
        end
        default: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rand_gen_ctrl.sv
// Directed bench for rand_gen_ctrl: drives requests and a scripted
// generator, records store writes and pulses, and compares against
// hand-derived expectations.
module tb_rand_gen_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_dim_m = '0;
  logic [2:0] req_dim_n = '0;
  logic [3:0] req_count = '0;
  logic [7:0] cfg_elem_min = '0;
  logic [7:0] cfg_elem_max = '0;
  logic       abort = 1'b0;
  logic       gen_start;
  logic [2:0] gen_dim_m;
  logic [2:0] gen_dim_n;
  logic [3:0] gen_count;
  logic       gen_write_en = 1'b0;
  logic [7:0] gen_data = '0;
  logic       gen_done = 1'b0;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] err_code;
  logic [2:0] res_base;
  logic [3:0] res_count;

  rand_gen_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dim_m(req_dim_m), .req_dim_n(req_dim_n), .req_count(req_count),
    .cfg_elem_min(cfg_elem_min), .cfg_elem_max(cfg_elem_max),
    .abort(abort),
    .gen_start(gen_start), .gen_dim_m(gen_dim_m), .gen_dim_n(gen_dim_n), .gen_count(gen_count),
    .gen_write_en(gen_write_en), .gen_data(gen_data), .gen_done(gen_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .res_base(res_base), .res_count(res_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int mon_addr[$];
  int mon_data[$];
  int mon_cyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_we) begin
      mon_addr.push_back(int'(mem_addr));
      mon_data.push_back(int'(mem_wdata));
      mon_cyc.push_back(cyc);
    end
    if (gen_start) start_cnt++;
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int m, input int n, input int c,
                        input logic [7:0] mn, input logic [7:0] mx);
    int k;
    k = 0;
    while (!req_ready && k < 300) begin
      tick();
      k++;
    end
    if (!req_ready) chk("req_ready_wait", 0, 1);
    req_dim_m    = 3'(m);
    req_dim_n    = 3'(n);
    req_count    = 4'(c);
    cfg_elem_min = mn;
    cfg_elem_max = mx;
    req_valid    = 1'b1;
    tick();
    req_valid    = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (gen_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("gen_start_seen", 0, 1);
  endtask

  // Full successful job; expected addresses come from slot arithmetic
  task automatic run_job(input int m, input int n, input int c, input int base, input bit bubble);
    int e, tot, q0, d0, e0, k, exp_addr;
    int scyc[$];
    bit ok;
    e = m * n;
    tot = e * c;
    q0 = mon_addr.size();
    d0 = done_cnt;
    e0 = err_cnt;
    do_req(m, n, c, 8'hFC, 8'h09);
    wait_start(ok);
    if (!ok) return;
    chk("gen_dim_m", gen_dim_m, m);
    chk("gen_dim_n", gen_dim_n, n);
    chk("gen_count", gen_count, c);
    chk("busy_run", busy, 1);
    chk("ready_run", req_ready, 0);
    for (int i = 0; i < tot; i++) begin
      gen_write_en = 1'b1;
      gen_data     = 8'(i * 13 + 5);
      gen_done     = (i == tot - 1);
      scyc.push_back(cyc);
      tick();
      if (bubble && (i % e == e - 1) && i != tot - 1) begin
        gen_write_en = 1'b0;
        tick();
      end
    end
    gen_write_en = 1'b0;
    gen_done     = 1'b0;
    k = 0;
    while (k < 5 && !done && !err) begin
      tick();
      k++;
    end
    chk("done_pulse", done, 1);
    chk("res_base", res_base, base);
    chk("res_count", res_count, c);
    chk("err_code_ok", err_code, 0);
    tick();
    chk("n_writes", mon_addr.size() - q0, tot);
    if (mon_addr.size() - q0 == tot) begin
      for (int i = 0; i < tot; i++) begin
        exp_addr = ((base + i / e) % 8) * 32 + (i % e);
        chk("wr_addr", mon_addr[q0 + i], exp_addr);
        chk("wr_data", mon_data[q0 + i], (i * 13 + 5) % 256);
        chk("wr_latency", mon_cyc[q0 + i] - scyc[i], 1);
      end
    end
    chk("done_count", done_cnt - d0, 1);
    chk("err_count_ok", err_cnt - e0, 0);
  endtask

  // Rejected request: err two cycles after accept, nothing started or written
  task automatic err_case(input string tag, input int m, input int n, input int c,
                          input logic [7:0] mn, input logic [7:0] mx, input int code);
    int s0, q0;
    s0 = start_cnt;
    q0 = mon_addr.size();
    do_req(m, n, c, mn, mx);
    chk({tag, "_err_early"}, err, 0);
    tick();
    chk({tag, "_err_mid"}, err, 0);
    tick();
    chk({tag, "_err"}, err, 1);
    chk({tag, "_code"}, err_code, code);
    chk({tag, "_ready"}, req_ready, 1);
    tick();
    chk({tag, "_no_start"}, start_cnt - s0, 0);
    chk({tag, "_no_write"}, mon_addr.size() - q0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got 0 expected 1");
    $fatal(1, "time limit");
  end

  initial begin
    int q0, d0, e0, k;
    bit ok;

    #2 rst = 1'b1;
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_res_base", res_base, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 2x3 x2 from slot 0, then again from slot 2 with inter-matrix bubbles
    run_job(2, 3, 2, 0, 1'b0);
    run_job(2, 3, 2, 2, 1'b1);

    err_case("dim_m0", 0, 3, 1, 8'h00, 8'h05, 1);
    err_case("dim_6x1", 6, 1, 1, 8'h00, 8'h05, 1);
    err_case("count0", 2, 2, 0, 8'h00, 8'h05, 2);
    err_case("count9", 2, 2, 9, 8'h00, 8'h05, 2);
    err_case("range", 2, 2, 1, 8'h05, 8'hFD, 3);
    err_case("prio", 7, 2, 0, 8'h05, 8'hFD, 1);

    // Advance pointer 4 -> 7, then wrap from slot 7 to slot 0
    run_job(1, 1, 3, 4, 1'b0);
    run_job(1, 1, 2, 7, 1'b0);

    // Generator stalls after 3 strobes
    q0 = mon_addr.size();
    d0 = done_cnt;
    e0 = err_cnt;
    do_req(2, 2, 1, 8'h00, 8'h10);
    wait_start(ok);
    for (int i = 0; i < 3; i++) begin
      gen_write_en = 1'b1;
      gen_data = 8'(i);
      tick();
    end
    gen_write_en = 1'b0;
    repeat (63) tick();
    chk("to_code_before", err_code, 0);
    tick();
    chk("to_code_at", err_code, 4);
    chk("to_busy", busy, 1);
    k = 0;
    while (!err && k < 200) begin
      tick();
      k++;
    end
    chk("to_err_pulse", err, 1);
    tick();
    chk("to_writes", mon_addr.size() - q0, 3);
    chk("to_no_done", done_cnt - d0, 0);
    chk("to_err_once", err_cnt - e0, 1);
    chk("to_ready", req_ready, 1);

    // Abort a 3x3 job after 4 strobes
    q0 = mon_addr.size();
    d0 = done_cnt;
    e0 = err_cnt;
    do_req(3, 3, 1, 8'h00, 8'h10);
    wait_start(ok);
    for (int i = 0; i < 4; i++) begin
      gen_write_en = 1'b1;
      gen_data = 8'(i);
      tick();
    end
    gen_write_en = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", busy, 1);
    for (int i = 4; i < 9; i++) begin
      gen_write_en = 1'b1;
      gen_data = 8'(i);
      gen_done = (i == 8);
      tick();
    end
    gen_write_en = 1'b0;
    gen_done = 1'b0;
    chk("ab_ready", req_ready, 1);
    chk("ab_code", err_code, 0);
    tick();
    chk("ab_writes", mon_addr.size() - q0, 4);
    chk("ab_no_err", err_cnt - e0, 0);
    chk("ab_no_done", done_cnt - d0, 0);

    // Pointer still at 1 after timeout and abort
    run_job(1, 1, 1, 1, 1'b0);

    // Reset in the middle of RUN
    do_req(2, 2, 1, 8'h00, 8'h10);
    wait_start(ok);
    for (int i = 0; i < 2; i++) begin
      gen_write_en = 1'b1;
      gen_data = 8'(i);
      tick();
    end
    gen_write_en = 1'b0;
    chk("mr_we_before", mem_we, 1);
    rst = 1'b1;
    #1;
    chk("mr_req_ready", req_ready, 1);
    chk("mr_busy", busy, 0);
    chk("mr_mem_we", mem_we, 0);
    chk("mr_gen_dim_m", gen_dim_m, 0);
    chk("mr_gen_count", gen_count, 0);
    chk("mr_res_base", res_base, 0);
    chk("mr_res_count", res_count, 0);
    tick();
    rst = 1'b0;
    tick();
    run_job(2, 2, 1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rand_gen_ctrl.md
Name: rand_gen_ctrl

Overview:
Sequencer for the random-matrix generator. Accepts a user generation request and validates dimensions, count and element range. Starts the generator and assigns each generated matrix a slot in the shared matrix store, converting generator write strobes into store addresses. Supervises the generator with a watchdog, checks the element count on completion, and supports abort with drain.

Parameters:
MAX_DIM, 5, largest legal row/column count
SLOTS, 8, matrix slots in store (power of 2)
SLOT_WORDS, 32, words reserved per slot (power of 2, >= MAX_DIM*MAX_DIM)
ADDR_W, 8, store address width = log2(SLOTS*SLOT_WORDS)
TIMEOUT, 64, max idle cycles between generator strobes in RUN

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  request strobe
req_ready  out  1  high only in IDLE
req_dim_m  in  3  rows
req_dim_n  in  3  cols
req_count  in  4  matrices requested
cfg_elem_min  in  8  signed lower bound
cfg_elem_max  in  8  signed upper bound
abort  in  1  cancel current job
gen_start  out  1  one-cycle generator start
gen_dim_m  out  3  latched rows
gen_dim_n  out  3  latched cols
gen_count  out  4  latched count
gen_write_en  in  1  generator element strobe
gen_data  in  8  generator element
gen_done  in  1  generator completion pulse
mem_we  out  1  store write
mem_addr  out  ADDR_W  slot*SLOT_WORDS + element index
mem_wdata  out  8  element
busy  out  1  not IDLE
done  out  1  one-cycle success pulse
err  out  1  one-cycle error pulse
err_code  out  3  0 none, 1 bad dim, 2 bad count, 3 bad range, 4 timeout, 5 count mismatch; held until next accept
res_base  out  log2(SLOTS)  first slot of last successful job
res_count  out  4  matrices in last successful job

Behaviour:
- Reset values:
  - All outputs 0, except req_ready=1.
  - State IDLE; slot pointer 0; all counters 0.
- IDLE:
  - On req_valid&&req_ready, latch m, n, count, min and max.
  - Clear err_code; go to CHECK.
- CHECK (1 cycle). Checks run in priority order; first failure wins:
  - m or n outside 1..MAX_DIM -> code 1
  - count outside 1..SLOTS -> code 2
  - cfg_elem_min > cfg_elem_max (signed) -> code 3
  - Any failure: go to ERROR. Otherwise go to START.
- ERROR: err=1 for one cycle; go to IDLE. No gen_start, no mem_we.
- START:
  - gen_start=1 for one cycle; gen_dim_*/gen_count hold latched values for the whole job.
  - Load cur_slot = slot pointer; elem_idx=0; total=0; watchdog=0; go to RUN.
- RUN:
  - Each gen_write_en: next cycle mem_we=1, mem_wdata=gen_data, mem_addr={cur_slot,elem_idx}.
  - elem_idx increments; when it reaches m*n-1 it wraps to 0 and cur_slot increments modulo SLOTS.
  - total increments on every strobe.
  - Generator inter-matrix bubble cycles are tolerated.
  - Watchdog counts cycles without gen_write_en and clears on each strobe. Reaching TIMEOUT -> code 4, go to DRAIN.
  - gen_done -> FINISH.
  - abort -> DRAIN, err_code stays 0.
  - abort and gen_done in the same cycle: abort wins.
- FINISH (1 cycle):
  - total == m*n*count: done=1, res_base=old slot pointer, res_count=count, slot pointer += count (mod SLOTS).
  - Otherwise: code 5, err=1, slot pointer unchanged.
- DRAIN:
  - mem_we forced 0; generator strobes discarded.
  - Exit to IDLE on gen_done, or after TIMEOUT idle cycles.
  - err=1 on exit if a code is set; done never asserted.
  - Slot pointer unchanged.
- mem_we for a strobe in the same cycle as gen_done is still issued.
- Widths: m*n*count needs 9 bits, computed unsigned; range compare is signed 8-bit.
- Reset mid-operation: immediate return to reset values; partially written slots are not reclaimed or marked.

Decomposition:
- Shared package (matrix_pkg): state encoding, err_code constants, MAX_DIM, SLOTS, SLOT_WORDS.
- Sub-module slot_addr_gen: elem_idx/cur_slot counters and mem_addr formation. The FSM stays in the top.

Test Plan:
- 2x3, count 2, min -4, max 9:
  - 12 mem_we at addr 0..5 then 32..37, each one cycle after its strobe.
  - done pulse, res_base 0, res_count 2.
  - A second identical request gets res_base 2.
- dim_m=0: err with code 1 two cycles after accept; no gen_start; req_ready back high.
- dim 6x1 -> code 1; count 0 -> code 2; min=5, max=-3 -> code 3. None issue gen_start.
- Slot pointer preloaded to 7, 1x1, count 2: writes to addr 224 then addr 0; res_base 7.
- Generator model stalls after 3 strobes: err code 4 exactly TIMEOUT cycles after the last strobe; done never asserted.
- abort after 4 of 9 strobes on a 3x3 job: no further mem_we; IDLE after gen_done; err_code 0; slot pointer unchanged.
- rst pulsed mid-RUN: all outputs at reset values same cycle; a new request then completes normally from slot 0.
